// File: rtl/latch_writer_pkg.sv
// latch_writer_pkg: shared state encoding and counter sizing for latch_writer
package latch_writer_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    // Width of a down-counter that must hold (max phase length - 1).
    function automatic int cnt_width(input int s, input int p, input int h);
        int m;
        m = (s > p) ? s : p;
        m = (m > h) ? m : h;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/latch_writer.sv
// latch_writer: sequenced writer driving d/le of a transparent-high latch bank
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   in_valid  : producer has a word
//   in_data   : word to write
//   in_ready  : word accepted this cycle (state IDLE)
//   d         : registered data bus to latch, changes only on accept
//   le        : registered latch enable, high for PULSE_CYC cycles
//   busy      : write sequence in progress
//   done      : one-cycle pulse on the last HOLD cycle
//   q_rb, err : latch readback and sticky mismatch flag, only when
//               LATCH_WRITER_READBACK_EN is defined
module latch_writer
    import latch_writer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] d,
    output logic             le,
    output logic             busy,
    output logic             done
`ifdef LATCH_WRITER_READBACK_EN
    ,
    input  logic [WIDTH-1:0] q_rb,
    output logic             err
`endif
);

    localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last;

    assign last     = (cnt == '0);
    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;
    assign done     = (state == HOLD) && last;

    // Each phase loads the counter with its length minus one on entry and
    // leaves when the counter reaches zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt - CW'(1);
        case (state)
            IDLE: begin
                cnt_n = S_LD;
                if (in_valid) state_n = SETUP;
            end
            SETUP: if (last) begin
                state_n = PULSE;
                cnt_n   = P_LD;
            end
            PULSE: if (last) begin
                state_n = HOLD;
                cnt_n   = H_LD;
            end
            HOLD: if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // le is registered from the next state so it is glitch-free and
    // aligned exactly with the PULSE phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            d     <= '0;
            le    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            le    <= (state_n == PULSE);
            if (in_ready && in_valid) d <= in_data;
        end
    end

`ifdef LATCH_WRITER_READBACK_EN
    // The latch has been transparent for the whole pulse, so on the first
    // HOLD cycle its output must equal d.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else          err <= err | ((state == HOLD) && (cnt == H_LD) && (q_rb != d));
    end
`endif

endmodule

// File: tb/tb_latch_writer.sv
// tb_latch_writer: directed bench for latch_writer with an offset-based reference model
module tb_latch_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n  = 1'b1;
    logic           in_valid = 1'b0;
    logic [3:0]     in_data  = 4'b0000;
    logic [1:0]     le_o, rdy_o, busy_o, done_o;
    logic [1:0][3:0] d_o;
`ifdef LATCH_WRITER_READBACK_EN
    logic           q_force = 1'b0;
    logic           cap_force = 1'b0;
    logic [1:0]     err_o;
    bit             err_m [2];
`endif

    latch_writer #(.WIDTH(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_o[0]), .d(d_o[0]), .le(le_o[0]), .busy(busy_o[0]), .done(done_o[0])
`ifdef LATCH_WRITER_READBACK_EN
        , .q_rb(q_force ? 4'b0000 : d_o[0]), .err(err_o[0])
`endif
    );

    latch_writer #(.WIDTH(4), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_o[1]), .d(d_o[1]), .le(le_o[1]), .busy(busy_o[1]), .done(done_o[1])
`ifdef LATCH_WRITER_READBACK_EN
        , .q_rb(q_force ? 4'b0000 : d_o[1]), .err(err_o[1])
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    int         cyc = 0;
    logic       cap_rst = 1'b0, cap_valid = 1'b0;
    logic [3:0] cap_data = 4'b0000;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        cap_rst   <= reset_n;
        cap_valid <= in_valid;
        cap_data  <= in_data;
`ifdef LATCH_WRITER_READBACK_EN
        cap_force <= q_force;
`endif
    end

    // Model: a write is a timeline of S+P+H cycles counted from the accept
    // edge; le is high for offsets [S, S+P), done at offset S+P+H-1.
    int         sp [2] = '{1, 3};
    int         pp [2] = '{2, 1};
    int         hp [2] = '{1, 2};
    bit         bm [2];
    int         off [2];
    logic [3:0] dw [2];
    int         acc [2], gap [2], le_cnt [2], le_dly [2], done_cnt [2], busy_cnt [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                bm[i]  = 1'b0;
                off[i] = 0;
                dw[i]  = 4'b0000;
`ifdef LATCH_WRITER_READBACK_EN
                err_m[i] = 1'b0;
`endif
            end else if (cap_rst) begin
                if (!bm[i]) begin
                    if (cap_valid) begin
                        bm[i]       = 1'b1;
                        off[i]      = 0;
                        dw[i]       = cap_data;
                        gap[i]      = cyc - acc[i];
                        acc[i]      = cyc;
                        le_cnt[i]   = 0;
                        le_dly[i]   = -1;
                        done_cnt[i] = 0;
                        busy_cnt[i] = 0;
                    end
                end else begin
`ifdef LATCH_WRITER_READBACK_EN
                    if (off[i] == sp[i] + pp[i] && cap_force && dw[i] != 4'b0000) err_m[i] = 1'b1;
`endif
                    off[i]++;
                    if (off[i] == sp[i] + pp[i] + hp[i]) bm[i] = 1'b0;
                end
            end
            chk($sformatf("d%0d", i), d_o[i], dw[i]);
            chk($sformatf("le%0d", i), le_o[i], int'(bm[i] && off[i] >= sp[i] && off[i] < sp[i] + pp[i]));
            chk($sformatf("done%0d", i), done_o[i], int'(bm[i] && off[i] == sp[i] + pp[i] + hp[i] - 1));
            chk($sformatf("busy%0d", i), busy_o[i], int'(bm[i]));
            chk($sformatf("in_ready%0d", i), rdy_o[i], int'(!bm[i]));
`ifdef LATCH_WRITER_READBACK_EN
            chk($sformatf("err%0d", i), err_o[i], int'(err_m[i]));
`endif
            if (le_o[i]) begin
                le_cnt[i]++;
                if (le_dly[i] < 0) le_dly[i] = cyc - acc[i];
            end
            if (done_o[i]) done_cnt[i]++;
            if (busy_o[i]) busy_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_d", d_o[0], 0);
        chk("rst_le", le_o[0], 0);
        chk("rst_ready", rdy_o[0], 1);
        reset_n = 1'b1;
        tick();

        // single write with defaults, both instances
        wr(4'b1010);
        repeat (8) tick();
        chk("w1_d", d_o[0], 4'b1010);
        chk("w1_le_width", le_cnt[0], 2);
        chk("w1_le_delay", le_dly[0], 1);
        chk("w1_done_cnt", done_cnt[0], 1);
        chk("w1_busy_cnt", busy_cnt[0], 4);
        chk("s3_le_width", le_cnt[1], 1);
        chk("s3_le_delay", le_dly[1], 3);
        chk("s3_busy_cnt", busy_cnt[1], 6);

        // back-to-back with in_valid held, in_data scrambled mid-sequence
        in_valid = 1'b1;
        in_data  = 4'b1111;
        tick();
        in_data = 4'b1001;
        repeat (4) tick();
        chk("b2b_d_hold", d_o[0], 4'b1111);
        in_data = 4'b0011;
        tick();
        settle();
        chk("b2b_gap", gap[0], 5);
        chk("b2b_d2", d_o[0], 4'b0011);
        chk("b2b_s3_d_hold", d_o[1], 4'b1111);
        tick();
        tick();
        in_valid = 1'b0;
        settle();
        chk("b2b_s3_gap", gap[1], 7);
        repeat (10) tick();

        // reset during PULSE
        wr(4'b1100);
        tick();
        chk("pulse_le", le_o[0], 1);
        reset_n = 1'b0;
        #1;
        chk("async_le", le_o[0], 0);
        chk("async_d", d_o[0], 0);
        chk("async_d_s3", d_o[1], 0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_ready", rdy_o[0], 1);
        wr(4'b0101);
        repeat (8) tick();
        chk("post_rst_d", d_o[0], 4'b0101);
        chk("post_rst_done", done_cnt[0], 1);
        chk("post_rst_le", le_cnt[0], 2);

`ifdef LATCH_WRITER_READBACK_EN
        wr(4'b1010);
        repeat (8) tick();
        chk("rb_good", err_o[0], 0);
        q_force = 1'b1;
        wr(4'b1010);
        repeat (8) tick();
        q_force = 1'b0;
        chk("rb_bad0", err_o[0], 1);
        chk("rb_bad1", err_o[1], 1);
        wr(4'b0110);
        repeat (8) tick();
        chk("rb_sticky", err_o[0], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
